// File: rtl/reg_write_decode_32.sv
// reg_write_decode_32: write side of the 32x32-bit register file (one-hot decoded single write port)
// Ports:
//   clk          rising-edge clock for all state
//   rst_n        asynchronous active-low reset; clears registers and status
//   wr_en        write strobe
//   wr_addr[4:0] destination register index
//   wr_data[31:0] write data
//   regs[1023:0] flat register image, register k at [32k+31:32k]
//   wr_onehot[31:0] registered one-hot of the last committed write (0 if none)
//   last_wr_addr[4:0] index of the most recent committed write
//   wr_count[15:0] committed writes since reset, wraps modulo 2^16
// Build option: define REG_ZERO_HARDWIRE_EN to make register 0 a constant zero.
module reg_write_decode_32 (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [4:0]    wr_addr,
    input  logic [31:0]   wr_data,
    output logic [1023:0] regs,
    output logic [31:0]   wr_onehot,
    output logic [4:0]    last_wr_addr,
    output logic [15:0]   wr_count
);
`ifdef REG_ZERO_HARDWIRE_EN
    localparam bit HZ = 1'b1;
`else
    localparam bit HZ = 1'b0;
`endif
    logic        commit;
    logic [31:0] dec;
    // Gating on wr_en first keeps X/Z on wr_addr from leaking into the decode when idle.
    always_comb begin
        commit = wr_en && !(HZ && wr_addr == 5'd0);
        dec    = commit ? (32'd1 << wr_addr) : '0;
    end
    genvar k;
    for (k = 0; k < 32; k++) begin : g_reg
        if (HZ && k == 0) begin : g_zero
            assign regs[31:0] = '0;
        end else begin : g_rw
            logic [31:0] r;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    r <= '0;
                else if (dec[k])
                    r <= wr_data;
            end
            assign regs[32*k +: 32] = r;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_onehot    <= '0;
            last_wr_addr <= '0;
            wr_count     <= '0;
        end else begin
            wr_onehot <= dec;
            if (commit) begin
                last_wr_addr <= wr_addr;
                wr_count     <= wr_count + 16'd1;
            end
        end
    end
endmodule

// File: doc/reg_write_decode_32.md
# reg_write_decode_32

Write side of the 32×32-bit general-purpose register file. A 5-to-32 one-hot decoder gates a single write port into 32 edge-triggered 32-bit registers. All 32 register values are exported as a flat bus, which feeds the 32-to-1 read-selection muxes. Sits in the decode/writeback boundary of the single-cycle datapath and is written once per cycle by the writeback stage.

## Interface
- No parameters; widths are fixed at 32 registers × 32 bits.
- clk  in  1  rising-edge clock for all state.
- rst_n  in  1  asynchronous active-low reset; clears every register and the status outputs.
- wr_en  in  1  write strobe, sampled at rising clk.
- wr_addr  in  5  destination register index, 0..31.
- wr_data  in  32  write data.
- regs  out  1024  flat register image; register k occupies bits [32k+31:32k].
- wr_onehot  out  32  registered one-hot of the last committed write; all zeros if no write committed that cycle.
- last_wr_addr  out  5  index of the most recent committed write; holds its value between writes.
- wr_count  out  16  number of committed writes since reset; wraps modulo 2^16.

## Operation
- Decoder: dec[k] = wr_en & (wr_addr == k), for k = 0..31. Exactly one bit is set when wr_en=1, and none when wr_en=0.
- Register k loads wr_data on the rising clk edge when dec[k]=1. Otherwise it holds.
- A write is "committed" when wr_en=1 at the edge and the target is writable (see Configuration). On commit:
  - wr_onehot <= dec;
  - last_wr_addr <= wr_addr;
  - wr_count <= wr_count + 1.
- With no commit, wr_onehot <= 0 and last_wr_addr and wr_count hold.
- wr_count wraps from 0xFFFF to 0x0000 with no flag or saturation.
- There is no internal forwarding. regs reflects only state that has already been committed.
- Values of wr_addr and wr_data are don't-care when wr_en=0, including X/Z. No register, counter or status output may change in that case.

## Timing
- Write latency is 1 cycle. Data presented with wr_en at edge N appears on regs immediately after edge N, and is readable combinationally through the read muxes in cycle N+1.
- The status outputs (wr_onehot, last_wr_addr, wr_count) update on the same edge as the register write.
- Reset values, asynchronous on rst_n falling, are independent of clk:
  - all 32 registers = 0x00000000;
  - wr_onehot = 0;
  - last_wr_addr = 0;
  - wr_count = 0.
- Reset asserted mid-cycle or coincident with a write edge: reset wins and the write is discarded.
- The first write edge after rst_n rises is honoured normally.
- Back-to-back writes to the same index in consecutive cycles: each write lands and the last one wins. wr_count increments once per edge.

## Configuration
- Macro: REG_ZERO_HARDWIRE_EN.
- Defined:
  - register 0 is constant 0x00000000 and is never written;
  - a write with wr_addr=0 is not committed: wr_onehot=0 that cycle, and last_wr_addr and wr_count are unchanged;
  - register 0 has no storage, and regs[31:0] is tied to 0.
- Undefined: register 0 is an ordinary writable register, identical to registers 1..31. A write to index 0 is committed and counted.

## Test plan
- Reset: drive rst_n=0 with no clock edge. Required: regs all zero, wr_onehot=0, last_wr_addr=0, wr_count=0.
- Sweep all indices: write k -> 0xA5A50000|k for k=0..31 in 32 consecutive cycles, then idle. Required:
  - register k reads 0xA5A50000|k, except register 0 reads 0x00000000 when REG_ZERO_HARDWIRE_EN is defined;
  - wr_count=32 without the macro, 31 with it;
  - last_wr_addr=31.
- Disabled write: set wr_en=0 with wr_addr=7, wr_data=0xDEADBEEF, and X on both for 5 cycles. Required: register 7, wr_onehot (=0) and wr_count are unchanged.
- Reset collision: write register 3 = 0x12345678, then assert rst_n low 2 ns before an edge that carries a write of register 3 = 0xFFFFFFFF. Required: register 3 = 0 and wr_count = 0 after reset releases; a following write of 0x1 to register 3 lands and gives wr_count=1.
- Wrap-around: 65536 consecutive writes to register 5. Required: wr_count=0x0000, register 5 holds the final data, wr_onehot=0x00000020 on the final cycle.
- Zero register, macro defined: write register 0 = 0xFFFFFFFF. Required: regs[31:0]=0, wr_onehot=0, last_wr_addr and wr_count unchanged.
